// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader that writes an instruction image and releases the core.
module program_loader #(
    parameter int         DATA_WIDTH     = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_WORDS      = 1024,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [DATA_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_opcode,
    output logic [DATA_WIDTH-1:0] imem_operand,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [1:0]            error_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] MAX_N     = DATA_WIDTH'(MAX_WORDS);
    localparam logic [TW-1:0]         TIMER_END = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, PAYLOAD, CHECK, DONE, ERR
    } state_t;

    state_t                state, state_next;
    logic [1:0]            err_next;
    logic [7:0]            count_hi;
    logic [DATA_WIDTH-1:0] n_words;
    logic [DATA_WIDTH-1:0] word_idx;
    logic [1:0]            byte_idx;
    logic [7:0]            sum;
    logic [DATA_WIDTH-1:0] asm_opcode;
    logic [7:0]            asm_operand_hi;
    logic [TW-1:0]         timer;

    logic                  xfer;
    logic                  in_frame;
    logic                  timeout_hit;
    logic                  last_word;
    logic [DATA_WIDTH-1:0] count_in;

    assign xfer        = rx_valid && rx_ready;
    assign in_frame    = (state == CNT_HI) || (state == CNT_LO) ||
                         (state == PAYLOAD) || (state == CHECK);
    assign timeout_hit = in_frame && !xfer && (timer == TIMER_END);
    assign last_word   = (byte_idx == 2'd3) && ((word_idx + DATA_WIDTH'(1)) == n_words);
    assign count_in    = {count_hi, rx_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        err_next   = 2'd0;
        case (state)
            IDLE:    if (xfer && rx_data == SYNC_BYTE) state_next = CNT_HI;
            CNT_HI:  if (xfer) state_next = CNT_LO;
            CNT_LO: begin
                if (xfer) begin
                    if (count_in > MAX_N) begin
                        state_next = ERR;
                        err_next   = 2'd2;
                    end else if (count_in == '0) begin
                        state_next = CHECK;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: if (xfer && last_word) state_next = CHECK;
            CHECK: begin
                if (xfer) begin
                    if (rx_data == sum) begin
                        state_next = DONE;
                    end else begin
                        state_next = ERR;
                        err_next   = 2'd1;
                    end
                end
            end
            default: state_next = state;
        endcase
        // timeout_hit implies no transfer, so it never races a legal byte
        if (timeout_hit) begin
            state_next = ERR;
            err_next   = 2'd3;
        end
    end

    always_comb begin
        rx_ready   = (state != DONE) && (state != ERR);
        cpu_hold   = (state != DONE);
        load_done  = (state == DONE);
        load_error = (state == ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_hi       <= '0;
            n_words        <= '0;
            word_idx       <= '0;
            byte_idx       <= '0;
            sum            <= '0;
            asm_opcode     <= '0;
            asm_operand_hi <= '0;
            timer          <= '0;
            imem_we        <= 1'b0;
            imem_addr      <= '0;
            imem_opcode    <= '0;
            imem_operand   <= '0;
            error_code     <= 2'd0;
        end else begin
            imem_we <= 1'b0;

            if (!in_frame || xfer) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end

            if (state_next == ERR && state != ERR) begin
                error_code <= err_next;
            end

            if (xfer) begin
                case (state)
                    IDLE: sum <= 8'd0;
                    CNT_HI: begin
                        count_hi <= rx_data;
                        sum      <= sum + rx_data;
                    end
                    CNT_LO: begin
                        n_words  <= count_in;
                        sum      <= sum + rx_data;
                        word_idx <= '0;
                        byte_idx <= 2'd0;
                    end
                    PAYLOAD: begin
                        sum      <= sum + rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        // output registers are separate from assembly so the next byte can land during the write
                        case (byte_idx)
                            2'd0: asm_opcode[15:8] <= rx_data;
                            2'd1: asm_opcode[7:0]  <= rx_data;
                            2'd2: asm_operand_hi   <= rx_data;
                            default: begin
                                imem_we      <= 1'b1;
                                imem_addr    <= word_idx;
                                imem_opcode  <= asm_opcode;
                                imem_operand <= {asm_operand_hi, rx_data};
                                word_idx     <= word_idx + DATA_WIDTH'(1);
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed-vector bench for program_loader.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [15:0] imem_addr, imem_opcode, imem_operand;
    logic        cpu_hold, load_done, load_error;
    logic [1:0]  error_code;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] wa[$];
    logic [15:0] wo[$];
    logic [15:0] wp[$];

    program_loader #(
        .DATA_WIDTH(16), .SYNC_BYTE(8'hA5), .MAX_WORDS(1024), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_opcode(imem_opcode), .imem_operand(imem_operand),
        .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(imem_addr);
            wo.push_back(imem_opcode);
            wp.push_back(imem_operand);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wa.delete(); wo.delete(); wp.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        vectors++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_rx_ready byte=%02h got=%b want=1", b, rx_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle_valid();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame1_body();
        logic [7:0] f[11] = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h01, 8'h00, 8'h05,
                              8'h30, 8'h02, 8'h12, 8'h34};
        for (int i = 0; i < 11; i++) send_byte(f[i]);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({rx_ready, cpu_hold, load_done, load_error, error_code, imem_we} !== 7'b1100000 ||
            imem_addr !== 16'h0 || imem_opcode !== 16'h0 || imem_operand !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b hold=%b done=%b err=%b code=%0d we=%b a=%h o=%h p=%h want 1 1 0 0 0 0 0 0 0",
                     rx_ready, cpu_hold, load_done, load_error, error_code, imem_we,
                     imem_addr, imem_opcode, imem_operand);
        end
    endtask

    task automatic test_load_two();
        do_reset();
        send_byte(8'h55);
        send_frame1_body();
        @(negedge clk);
        rx_data = 8'h90;
        rx_valid = 1'b1;
        vectors++;
        if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL hold_before_chk got hold=%b done=%b want 1 0", cpu_hold, load_done);
        end
        @(posedge clk);
        idle_valid();
        vectors++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || rx_ready !== 1'b0 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL load_two_done got done=%b hold=%b rdy=%b err=%b want 1 0 0 0",
                     load_done, cpu_hold, rx_ready, load_error);
        end
        vectors++;
        if (wa.size() !== 2 || wa[0] !== 16'h0000 || wo[0] !== 16'h1001 || wp[0] !== 16'h0005 ||
            wa[1] !== 16'h0001 || wo[1] !== 16'h3002 || wp[1] !== 16'h1234) begin
            errors++;
            $display("FAIL load_two_writes got n=%0d w0=%h/%h/%h w1=%h/%h/%h want 2 0000/1001/0005 0001/3002/1234",
                     wa.size(), wa[0], wo[0], wp[0], wa[1], wo[1], wp[1]);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        send_frame1_body();
        send_byte(8'h8F);
        idle_valid();
        vectors++;
        if (load_error !== 1'b1 || error_code !== 2'd1 || cpu_hold !== 1'b1 ||
            load_done !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL bad_chk got err=%b code=%0d hold=%b done=%b rdy=%b want 1 1 1 0 0",
                     load_error, error_code, cpu_hold, load_done, rx_ready);
        end
        vectors++;
        if (wa.size() !== 2 || wo[1] !== 16'h3002 || wp[1] !== 16'h1234) begin
            errors++;
            $display("FAIL bad_chk_writes got n=%0d w1=%h/%h want 2 3002/1234", wa.size(), wo[1], wp[1]);
        end
    endtask

    task automatic test_empty_image();
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        rx_data = 8'h00;
        rx_valid = 1'b1;
        vectors++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL empty_early got done=%b want 0", load_done);
        end
        @(posedge clk);
        idle_valid();
        vectors++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || wa.size() !== 0) begin
            errors++;
            $display("FAIL empty_done got done=%b hold=%b writes=%0d want 1 0 0", load_done, cpu_hold, wa.size());
        end
    endtask

    task automatic test_count_limit();
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        idle_valid();
        vectors++;
        if (load_error !== 1'b1 || error_code !== 2'd2 || rx_ready !== 1'b0 || wa.size() !== 0) begin
            errors++;
            $display("FAIL count_too_big got err=%b code=%0d rdy=%b writes=%0d want 1 2 0 0",
                     load_error, error_code, rx_ready, wa.size());
        end
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h00);
        idle_valid();
        vectors++;
        if (load_error !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL count_max_legal got err=%b rdy=%b want 0 1", load_error, rx_ready);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h10);
        idle_valid();
        repeat (15) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (load_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got err=%b want 0 after 15 idle", load_error);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (load_error !== 1'b1 || error_code !== 2'd3 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire got err=%b code=%0d hold=%b want 1 3 1", load_error, error_code, cpu_hold);
        end
        for (int g = 14; g <= 15; g++) begin
            do_reset();
            send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h10);
            idle_valid();
            repeat (g) @(posedge clk);
            send_byte(8'h20);
            idle_valid();
            vectors++;
            if (load_error !== 1'b0) begin
                errors++;
                $display("FAIL timeout_saved gap=%0d got err=%b want 0", g, load_error);
            end
            repeat (14) @(posedge clk);
            @(negedge clk);
            vectors++;
            if (load_error !== 1'b0) begin
                errors++;
                $display("FAIL timeout_restart gap=%0d got err=%b want 0", g, load_error);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p[9] = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h01, 8'h00, 8'h05, 8'h30, 8'h02};
        do_reset();
        for (int i = 0; i < 9; i++) send_byte(p[i]);
        @(negedge clk);
        rx_data = 8'h77;
        rx_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rx_valid = 1'b0;
        vectors++;
        if ({rx_ready, cpu_hold, load_done, load_error, error_code} !== 6'b110000 ||
            imem_addr !== 16'h0 || imem_opcode !== 16'h0 || imem_operand !== 16'h0) begin
            errors++;
            $display("FAIL midframe_reset got rdy=%b hold=%b done=%b err=%b code=%0d a=%h o=%h p=%h want 1 1 0 0 0 0 0 0",
                     rx_ready, cpu_hold, load_done, load_error, error_code,
                     imem_addr, imem_opcode, imem_operand);
        end
        wa.delete(); wo.delete(); wp.delete();
        send_frame1_body();
        send_byte(8'h90);
        idle_valid();
        vectors++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || wa.size() !== 2 ||
            wa[0] !== 16'h0000 || wo[0] !== 16'h1001 || wp[0] !== 16'h0005 ||
            wa[1] !== 16'h0001 || wo[1] !== 16'h3002 || wp[1] !== 16'h1234) begin
            errors++;
            $display("FAIL back_to_back got done=%b hold=%b n=%0d w0=%h/%h/%h w1=%h/%h/%h want 1 0 2 0000/1001/0005 0001/3002/1234",
                     load_done, cpu_hold, wa.size(), wa[0], wo[0], wp[0], wa[1], wo[1], wp[1]);
        end
    endtask

    initial begin
        test_reset();
        test_load_two();
        test_bad_checksum();
        test_empty_image();
        test_count_limit();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
